// File: rtl/prbs31_if.sv
// Receive-side bundle for the PRBS31 checker: serial bit stream in, lock status and error statistics out.
interface prbs31_if #(
  parameter int CNT_W  = 16,
  parameter int BCNT_W = 32
);
  logic              bit_in;
  logic              bit_valid;
  logic              clear;
  logic              locked;
  logic              err_pulse;
  logic              sync_loss;
  logic              err_seen;
  logic [CNT_W-1:0]  err_count;
  logic [BCNT_W-1:0] bit_count;

  modport master (
    output bit_in, bit_valid, clear,
    input  locked, err_pulse, sync_loss, err_seen, err_count, bit_count
  );

  modport slave (
    input  bit_in, bit_valid, clear,
    output locked, err_pulse, sync_loss, err_seen, err_count, bit_count
  );
endinterface

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 (x^31 + x^28 + 1) serial checker: seeds from the line,
// qualifies lock on consecutive predictions, then free-runs and counts bit errors.
module prbs31_checker #(
  parameter int LOCK_CNT   = 32,
  parameter int ERR_WIN    = 64,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16,
  parameter int BCNT_W     = 32
) (
  input logic      clk,
  input logic      rst_n,
  prbs31_if.slave  bus
);

  localparam logic [1:0] ST_SEED = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(ERR_WIN + 1);

  logic [1:0]        state;
  logic [30:0]       hist;
  logic [4:0]        seed_cnt;
  logic [MW-1:0]     match_cnt;
  logic [WW-1:0]     win_cnt;
  logic [WW-1:0]     win_err;

  logic              locked_q;
  logic              err_pulse_q;
  logic              sync_loss_q;
  logic              err_seen_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [BCNT_W-1:0] bit_count_q;

  logic              exp_bit;
  logic              in_lock;
  logic              err_now;
  logic              acq_match;
  logic [WW-1:0]     win_err_nx;
  logic              thresh_hit;
  logic              win_last;

  function automatic logic [CNT_W-1:0] sat_inc_err(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [BCNT_W-1:0] sat_inc_bit(input logic [BCNT_W-1:0] v);
    return (&v) ? v : v + BCNT_W'(1);
  endfunction

  assign exp_bit    = hist[27] ^ hist[30];
  assign in_lock    = (state == ST_LOCK) && bus.bit_valid;
  assign err_now    = in_lock && (bus.bit_in != exp_bit);
  // An all-zero history predicts zero forever, so it must never count toward lock.
  assign acq_match  = (bus.bit_in == exp_bit) && (hist != 31'd0);
  assign win_err_nx = win_err + WW'(err_now);
  assign thresh_hit = in_lock && (win_err_nx == WW'(ERR_THRESH));
  assign win_last   = (win_cnt == WW'(ERR_WIN - 1));

  // Sync FSM, history register and loss-of-sync window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SEED;
      hist        <= '0;
      seed_cnt    <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
      if (bus.bit_valid) begin
        case (state)
          ST_SEED: begin
            hist <= {hist[29:0], bus.bit_in};
            if (seed_cnt == 5'd30) begin
              state     <= ST_ACQ;
              seed_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              seed_cnt <= seed_cnt + 5'd1;
            end
          end
          ST_ACQ: begin
            hist <= {hist[29:0], bus.bit_in};
            if (acq_match) begin
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                state     <= ST_LOCK;
                locked_q  <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCK: begin
            // Feeding back the prediction keeps a line error from corrupting later predictions.
            hist        <= {hist[29:0], exp_bit};
            err_pulse_q <= err_now;
            if (thresh_hit) begin
              state       <= ST_SEED;
              locked_q    <= 1'b0;
              sync_loss_q <= 1'b1;
              seed_cnt    <= '0;
              win_cnt     <= '0;
              win_err     <= '0;
            end else if (win_last) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + WW'(1);
              win_err <= win_err_nx;
            end
          end
          default: begin
            state    <= ST_SEED;
            locked_q <= 1'b0;
            seed_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Statistics: clear wins over a same-cycle increment and leaves sync state alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
      bit_count_q <= '0;
      err_seen_q  <= 1'b0;
    end else if (bus.clear) begin
      err_count_q <= '0;
      bit_count_q <= '0;
      err_seen_q  <= 1'b0;
    end else if (in_lock) begin
      bit_count_q <= sat_inc_bit(bit_count_q);
      if (err_now) begin
        err_count_q <= sat_inc_err(err_count_q);
        err_seen_q  <= 1'b1;
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.sync_loss = sync_loss_q;
  assign bus.err_seen  = err_seen_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboarded bench for prbs31_checker: a default-parameter instance plus a narrow-counter instance
// share one PRBS31 stream with known injected flips; expectations come from sample counts and flip positions.
module tb_prbs31_checker;

  localparam int LOCK_CNT  = 32;
  localparam int ERR_WIN   = 64;
  localparam int THRESH    = 8;
  localparam int LOCK_BITS = 31 + LOCK_CNT;
  localparam int EMAX1     = 65535;
  localparam int EMAX2     = 15;
  localparam longint BMAX  = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic drv_bit, drv_vld, drv_clr;

  prbs31_if #(.CNT_W(16), .BCNT_W(32)) bus1 ();
  prbs31_if #(.CNT_W(4),  .BCNT_W(32)) bus2 ();

  assign bus1.bit_in    = drv_bit;
  assign bus1.bit_valid = drv_vld;
  assign bus1.clear     = drv_clr;
  assign bus2.bit_in    = drv_bit;
  assign bus2.bit_valid = drv_vld;
  assign bus2.clear     = drv_clr;

  prbs31_checker #(.LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_THRESH(THRESH),
                   .CNT_W(16), .BCNT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  prbs31_checker #(.LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_THRESH(ERR_WIN),
                   .CNT_W(4), .BCNT_W(32)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    bit          locked;
    bit          err_pulse;
    bit          sync_loss;
    bit          err_seen;
    int unsigned err_count;
    longint      bit_count;
    bit          locked2;
    int unsigned err_count2;
    bit          err_seen2;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (spec-level: samples since seeding began, known flip positions)
  bit          m_locked, m_pulse, m_sync, m_seen;
  int          m_cnt, m_wcnt, m_werr;
  int unsigned m_errc;
  longint      m_bitc;
  bit          m2_locked, m2_seen;
  int          m2_cnt;
  int unsigned m2_errc;
  bit          zero_mode = 1'b0;

  // PRBS31 source, restarted from a state of 1 on every reset
  bit gw[$];
  int gen_n = 0;

  function automatic bit gen_next();
    bit b;
    if (gen_n < 31) b = (gen_n == 0);
    else            b = gw[3] ^ gw[0];
    gw.push_back(b);
    if (gw.size() > 31) void'(gw.pop_front());
    gen_n++;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_pulse = 0; m_sync = 0; m_seen = 0;
    m_cnt = 0; m_wcnt = 0; m_werr = 0; m_errc = 0; m_bitc = 0;
    m2_locked = 0; m2_seen = 0; m2_cnt = 0; m2_errc = 0;
  endtask

  task automatic model_step(input bit rst, input bit bv, input bit flip, input bit clr);
    if (!rst) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    m_sync  = 0;
    if (bv) begin
      if (!m_locked) begin
        if (!zero_mode) m_cnt++;
        if (m_cnt == LOCK_BITS) begin
          m_locked = 1; m_wcnt = 0; m_werr = 0;
        end
      end else begin
        if (m_bitc < BMAX) m_bitc++;
        if (flip) begin
          m_pulse = 1; m_seen = 1; m_werr++;
          if (m_errc < EMAX1) m_errc++;
        end
        if (m_werr == THRESH) begin
          m_locked = 0; m_cnt = 0; m_sync = 1;
        end else if (m_wcnt == ERR_WIN - 1) begin
          m_wcnt = 0; m_werr = 0;
        end else begin
          m_wcnt++;
        end
      end
      if (!m2_locked) begin
        if (!zero_mode) m2_cnt++;
        if (m2_cnt == LOCK_BITS) m2_locked = 1;
      end else if (flip) begin
        m2_seen = 1;
        if (m2_errc < EMAX2) m2_errc++;
      end
    end
    if (clr) begin
      m_errc = 0; m_bitc = 0; m_seen = 0;
      m2_errc = 0; m2_seen = 0;
    end
  endtask

  task automatic cycle(input bit rst, input bit bv, input bit flip_req, input bit clr);
    exp_t e;
    bit   prev, flip, b;
    @(negedge clk);
    prev = rst_n;
    flip = flip_req && m_locked && bv && rst;
    rst_n = rst;
    if (!rst) begin
      gw.delete();
      gen_n = 0;
      b = 1'($urandom);
    end else if (bv) begin
      b = zero_mode ? 1'b0 : gen_next();
    end else begin
      b = 1'($urandom);
    end
    drv_bit = b ^ flip;
    drv_vld = bv;
    drv_clr = clr;
    model_step(rst, bv, flip, clr);
    e.locked = m_locked;   e.err_pulse = m_pulse; e.sync_loss = m_sync;
    e.err_seen = m_seen;   e.err_count = m_errc;  e.bit_count = m_bitc;
    e.locked2 = m2_locked; e.err_count2 = m2_errc; e.err_seen2 = m2_seen;
    sbq.push_back(e);
    if (prev && !rst) begin
      #1;
      chk("async_rst_locked",    64'(bus1.locked),    64'd0);
      chk("async_rst_err_pulse", 64'(bus1.err_pulse), 64'd0);
      chk("async_rst_sync_loss", 64'(bus1.sync_loss), 64'd0);
      chk("async_rst_err_seen",  64'(bus1.err_seen),  64'd0);
      chk("async_rst_err_count", 64'(bus1.err_count), 64'd0);
      chk("async_rst_bit_count", 64'(bus1.bit_count), 64'd0);
      chk("async_rst_locked2",   64'(bus2.locked),    64'd0);
    end
  endtask

  task automatic do_reset();
    repeat (2) cycle(0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clock edge presents a fresh output set
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("locked",     64'(bus1.locked),    64'(e.locked));
        chk("err_pulse",  64'(bus1.err_pulse), 64'(e.err_pulse));
        chk("sync_loss",  64'(bus1.sync_loss), 64'(e.sync_loss));
        chk("err_seen",   64'(bus1.err_seen),  64'(e.err_seen));
        chk("err_count",  64'(bus1.err_count), 64'(e.err_count));
        chk("bit_count",  64'(bus1.bit_count), 64'(e.bit_count));
        chk("locked2",    64'(bus2.locked),    64'(e.locked2));
        chk("err_count2", 64'(bus2.err_count), 64'(e.err_count2));
        chk("err_seen2",  64'(bus2.err_seen),  64'(e.err_seen2));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; drv_bit = 1'b0; drv_vld = 1'b0; drv_clr = 1'b0;
    model_reset();
    repeat (3) cycle(0, 0, 0, 0);

    // Clean stream: lock on 63rd bit, bit_count = N - 63
    repeat (10000) cycle(1, 1, 0, 0);
    settle();
    chk("clean_locked",    64'(bus1.locked),    64'd1);
    chk("clean_err_count", 64'(bus1.err_count), 64'd0);
    chk("clean_bit_count", 64'(bus1.bit_count), 64'(10000 - LOCK_BITS));

    // Single flip while locked
    cycle(1, 1, 1, 0);
    repeat (1000) cycle(1, 1, 0, 0);
    settle();
    chk("flip1_err_count", 64'(bus1.err_count), 64'd1);
    chk("flip1_err_seen",  64'(bus1.err_seen),  64'd1);
    chk("flip1_locked",    64'(bus1.locked),    64'd1);

    // Clear with an error on the same sample
    cycle(1, 1, 1, 1);
    settle();
    chk("clr_err_count", 64'(bus1.err_count), 64'd0);
    chk("clr_err_seen",  64'(bus1.err_seen),  64'd0);
    repeat (50) cycle(1, 1, 0, 0);

    // bit_valid one cycle in three
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1, (i % 3) == 0, 0, 0);
    settle();
    chk("sparse_locked",    64'(bus1.locked),    64'd1);
    chk("sparse_bit_count", 64'(bus1.bit_count), 64'(100 - LOCK_BITS));

    // Eight flips inside one window force loss of sync, then relock
    do_reset();
    repeat (70) cycle(1, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(1, 1, 1, 0);
      repeat (4) cycle(1, 1, 0, 0);
    end
    settle();
    chk("loss_locked",    64'(bus1.locked),    64'd0);
    chk("loss_err_count", 64'(bus1.err_count), 64'd8);
    repeat (100) cycle(1, 1, 0, 0);
    settle();
    chk("relock_locked",    64'(bus1.locked),    64'd1);
    chk("relock_err_count", 64'(bus1.err_count), 64'd8);

    // All-zero line never locks
    do_reset();
    zero_mode = 1'b1;
    repeat (500) cycle(1, 1, 0, 0);
    settle();
    chk("zero_locked", 64'(bus1.locked), 64'd0);
    zero_mode = 1'b0;
    do_reset();

    // Up to seven flips per window with random gaps in bit_valid
    repeat (70) cycle(1, 1, 0, 0);
    for (int i = 0; i < 1000; i++)
      cycle(1, $urandom_range(0, 3) != 0, (m_werr < THRESH - 1) && ($urandom_range(0, 5) == 0), 0);
    settle();
    chk("win7_locked", 64'(bus1.locked), 64'd1);

    // Twenty sparse errors saturate the 4-bit counter at 15
    repeat (64) cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 1);
    for (int k = 0; k < 20; k++) begin
      cycle(1, 1, 1, 0);
      repeat (9) cycle(1, 1, 0, 0);
    end
    settle();
    chk("sat_err_count2", 64'(bus2.err_count), 64'd15);
    chk("sat_err_count1", 64'(bus1.err_count), 64'd20);
    chk("sat_locked",     64'(bus1.locked),    64'd1);

    // Reset mid-lock
    do_reset();
    repeat (80) cycle(1, 1, 0, 0);
    do_reset();
    repeat (20) cycle(1, 1, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      cycle(1, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 200) == 0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
